// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default geometry,
// reset/write-enable polarities and the zero word.
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  typedef logic [DEF_DATA_W-1:0] word_t;
  localparam word_t ZERO_WORD = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: packed write ports, read ports and scoreboard alloc.
// No handshake: every field is sampled on each rising clk edge; reads are combinational.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  alloc_en;
  logic [ADDR_W-1:0]     alloc_addr;

  modport master (
    output we, waddr, wdata, rd_en, rd_addr, alloc_en, alloc_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  we, waddr, wdata, rd_en, rd_addr, alloc_en, alloc_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: alloc sets, any write clears, alloc wins on a collision.
// Entry 0 is hard-wired clear.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NWR    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NWR-1:0]          we,
  input  logic [NWR*ADDR_W-1:0]   waddr,
  input  logic                    alloc_en,
  input  logic [ADDR_W-1:0]       alloc_addr,
  output logic [(1<<ADDR_W)-1:0]  busy
);

  logic [(1<<ADDR_W)-1:0] busy_d;
  logic [(1<<ADDR_W)-1:0] busy_q;

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (we[k] == WRITE_ENABLE) begin
        busy_d[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (alloc_en && (alloc_addr != '0)) begin
      busy_d[alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with r0 hard-wired to zero, write-to-read bypass
// and a busy-bit scoreboard for issue tracking.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic [ADDR_W-1:0] ra      [NRD];
  logic [DATA_W-1:0] rval    [NRD];
  logic [NRD-1:0]    wr_hit;
  logic [NRD-1:0]    al_hit;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NWR    (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .we         (bus.we),
    .waddr      (bus.waddr),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .busy       (busy)
  );

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NWR; k++) begin
      if ((bus.we[k] == WRITE_ENABLE) && (bus.waddr[k*ADDR_W +: ADDR_W] != '0)) begin
        mem_d[bus.waddr[k*ADDR_W +: ADDR_W]] = bus.wdata[k*DATA_W +: DATA_W];
      end
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // rd_busy hides a busy bit only when a same-cycle write retires it and no
  // same-cycle alloc re-arms it.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    wr_hit      = '0;
    al_hit      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra[i]   = bus.rd_addr[i*ADDR_W +: ADDR_W];
      rval[i] = mem_q[ra[i]];
      for (int k = 0; k < NWR; k++) begin
        if ((bus.we[k] == WRITE_ENABLE) && (bus.waddr[k*ADDR_W +: ADDR_W] == ra[i])) begin
          wr_hit[i] = 1'b1;
          rval[i]   = bus.wdata[k*DATA_W +: DATA_W];
        end
      end
      al_hit[i] = bus.alloc_en && (bus.alloc_addr == ra[i]);
      if ((rst != RST_ENABLE) && bus.rd_en[i] && (ra[i] != '0)) begin
        bus.rd_data[i*DATA_W +: DATA_W] = rval[i];
        bus.rd_busy[i] = busy[ra[i]] && !(wr_hit[i] && !al_hit[i]);
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
- REQ-001 Parameter DATA_W, default 32, register width in bits.
- REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
- REQ-003 Parameter NRD, default 2, number of read ports (1..4).
- REQ-004 Parameter NWR, default 2, number of write ports (1..2).
- REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
- REQ-006 Port clk, input, 1, sole clock; all state updates on its rising edge.
- REQ-007 Port rst, input, 1, asynchronous active-high reset.
- REQ-008 Port we, input, NWR, per-write-port enable.
- REQ-009 Port waddr, input, NWR*ADDR_W, packed write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- REQ-010 Port wdata, input, NWR*DATA_W, packed write data.
- REQ-011 Port rd_en, input, NRD, per-read-port enable.
- REQ-012 Port rd_addr, input, NRD*ADDR_W, packed read addresses.
- REQ-013 Port rd_data, output, NRD*DATA_W, packed read data.
- REQ-014 Port rd_busy, output, NRD, scoreboard busy flag of the addressed register.
- REQ-015 Port alloc_en, input, 1, marks register alloc_addr as pending a write.
- REQ-016 Port alloc_addr, input, ADDR_W, register to mark busy.

Function
- REQ-017 Register array SHALL be written only on the rising clk edge, for each port k with we[k]=1 and waddr[k]!=0.
- REQ-018 Register 0 SHALL read 0 at all times, SHALL never be written, and SHALL never be busy.
- REQ-019 Same-cycle writes to the same address SHALL resolve with the highest-index port winning.
- REQ-020 Read ports SHALL be combinational (zero-cycle latency) from rd_addr to rd_data.
- REQ-021 rd_en[i]=0 SHALL force rd_data[i]=0 and rd_busy[i]=0.
- REQ-022 Bypass: when a write port targets rd_addr[i]!=0 in the same cycle, rd_data[i] SHALL return that write's wdata, using the winning port per REQ-019; otherwise it returns the stored value.
- REQ-023 Scoreboard: DEPTH busy bits; alloc_en=1 with alloc_addr!=0 SHALL set busy[alloc_addr] at the next edge.
- REQ-024 A write (we[k]=1) to address a SHALL clear busy[a] at the next edge.
- REQ-025 Same-cycle alloc and write to the same address: alloc wins and busy stays or becomes 1; the data is still written.
- REQ-026 rd_busy[i] SHALL reflect the registered busy bit, not a same-cycle bypass: it reports 0 only if busy is clear or a write to that address occurs in the same cycle and no same-cycle alloc targets it.
- REQ-027 Writes SHALL occur regardless of busy state; the scoreboard only advises the issuer.

Reset
- REQ-028 rst=1 SHALL asynchronously clear all registers to 0 and all busy bits to 0.
- REQ-029 While rst=1, rd_data SHALL be 0 and rd_busy SHALL be 0 on all ports, and writes and allocs SHALL be ignored.
- REQ-030 Reset asserted mid-operation SHALL discard any write or alloc in that cycle; the first edge after deassertion is a normal cycle.

Structure
- REQ-031 Zero, RstEnable and write-enable constants and the default DATA_W and ADDR_W SHALL live in the shared define package.
- REQ-032 Scoreboard logic SHALL be one sub-module, regfile_scoreboard, holding the busy bits and their set/clear priority.

Verification
- REQ-033 Reset, then read r1..r31 -> all 0, rd_busy=0.
- REQ-034 Write r5=0x0000_1234 on port 0 while reading r5 in the same cycle -> rd_data=0x0000_1234 (bypass); next cycle stored value is 0x0000_1234.
- REQ-035 Port 0 writes r7=0xAAAA_AAAA and port 1 writes r7=0x5555_5555 in the same cycle -> read r7 = 0x5555_5555.
- REQ-036 Write r0=0xFFFF_FFFF and alloc r0 -> read r0 = 0, rd_busy=0.
- REQ-037 Alloc r3 -> rd_busy=1; write r3 -> busy cleared next cycle; alloc r3 and write r3 in the same cycle -> busy=1 and data updated.
- REQ-038 Assert rst asynchronously between edges after writing r9=0x1 -> rd_data=0 immediately; after release r9 reads 0.
